context_switch_engine: RTL and testbench
========================================

Name: context_switch_engine

Overview:
- Fast_Clock-domain responder to the process scheduler's Snapshot / Update_PC / Load_Proc / Proc_ID handshake.
- On a Snapshot rising edge it stalls the core and saves the outgoing process's register file into a per-process context RAM.
- It then pulses Update_PC so the scheduler swaps PCs and Proc_ID, waits for Load_Proc, and restores the incoming process's registers.
- Sits between the scheduler, the register file and the core stall input.

Parameters:
- DATA_W, 32, register width
- REG_COUNT, 32, registers saved/restored per process
- ADDR_W, 5, register address width (clog2 REG_COUNT)
- PROC_COUNT, 4, process slots (Proc_ID width 2)
- UPD_PULSE, 2, Update_PC high time in Fast_Clock cycles
- LOAD_TIMEOUT, 1023, max cycles waiting for Load_Proc before error

Ports:
- Fast_Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- Snapshot  in  1  scheduler request; rising edge starts a switch
- Load_Proc  in  1  scheduler ready: new Proc_ID/PC valid
- Proc_ID  in  2  scheduler's current process ID
- Reg_Rd_Data  in  DATA_W  register file read data (1-cycle synchronous read)
- Reg_Addr  out  ADDR_W  register file read/write address
- Reg_Wr_Data  out  DATA_W  register file write data
- Reg_Wr_En  out  1  register file write strobe
- Update_PC  out  1  PC swap request to scheduler
- Stall  out  1  holds core (PC, writeback) while high
- Busy  out  1  switch in progress
- Overrun  out  1  sticky: Snapshot edge arrived while Busy
- Timeout_Err  out  1  sticky: Load_Proc not seen within LOAD_TIMEOUT

Behaviour:
- Reset: the interface is decided as reset Reset, synchronous, active-high; clock Fast_Clock.
- Reset values: all outputs 0; FSM to IDLE; counters 0; Snapshot_q 0.
- Context RAM contents are not cleared by Reset.
- Reset mid-operation aborts immediately. A partially restored register file is left as-is.
- Edge detect: start = Snapshot & ~Snapshot_q, with Snapshot_q registered every cycle.
- IDLE:
  - On start, latch Old_ID = Proc_ID, set idx=0, go SAVE.
  - Stall and Busy assert in the cycle after start and stay high until DONE completes.
- SAVE: Reg_Addr=idx each cycle. Reg_Rd_Data for idx-1 is written to ctx[Old_ID][idx-1] (skipped when idx=0). idx increments. When idx==REG_COUNT-1 has been issued, go SAVE_FLUSH.
- SAVE_FLUSH: write the last word to ctx[Old_ID][REG_COUNT-1]; go UPDATE. Save phase = REG_COUNT+1 cycles.
- UPDATE: Update_PC=1 for exactly UPD_PULSE cycles; then go WAIT_LOAD with timer=0.
- WAIT_LOAD:
  - Load_Proc sampled only from the cycle after Update_PC falls.
  - When Load_Proc==1, latch New_ID = Proc_ID.
  - If New_ID==Old_ID, go DONE and skip the restore.
  - Otherwise set idx=0 and go RESTORE.
  - timer reaching LOAD_TIMEOUT: set Timeout_Err, go DONE with no restore.
- RESTORE: ctx RAM read address {New_ID, idx} (1-cycle sync read). The cycle after, drive Reg_Addr=idx-1, Reg_Wr_Data=RAM data, Reg_Wr_En=1. After idx REG_COUNT-1 is issued, go RESTORE_FLUSH.
- RESTORE_FLUSH: write the last register; go DONE. Restore phase = REG_COUNT+1 cycles.
- DONE: one cycle, Reg_Wr_En=0; Stall and Busy drop on exit to IDLE.
- Latency: start edge to Update_PC rise = REG_COUNT+3 cycles (32-reg default: 35).
- Snapshot edge while Busy: ignored; Overrun set (sticky until Reset).
- Snapshot held high across a whole switch does not retrigger; a new rising edge is required.
- Reg_Wr_En is never asserted in SAVE states. Reg_Addr is don't-care (hold 0) outside SAVE/RESTORE.
- RAM addressing: {ID[1:0], idx[ADDR_W-1:0]}, depth PROC_COUNT*REG_COUNT, no wrap across ID slots.

Decomposition:
- Shared package (ctx_pkg):
  - FSM state enum (IDLE, SAVE, SAVE_FLUSH, UPDATE, WAIT_LOAD, RESTORE, RESTORE_FLUSH, DONE)
  - PROC_ID_W=2
  - default DATA_W/REG_COUNT constants
- Sub-module context_ram: single-port synchronous RAM, DATA_W x PROC_COUNT*REG_COUNT, write-enable, 1-cycle read latency.
- FSM and counters stay in context_switch_engine.

Test Plan:
- Basic save:
  - Stimulus: regfile model holds r[i]=0xA000_0000+i, Proc_ID=1, Snapshot 0->1.
  - Required: Stall high next cycle; ctx[1][0..31] == 0xA0000000..0xA000001F; Update_PC rises at cycle 35 and is high 2 cycles.
- Full round trip:
  - Stimulus: preload ctx[2][i]=0xB0000000+i; after Update_PC, model sets Proc_ID=2 and Load_Proc=1.
  - Required: 32 Reg_Wr_En pulses, addresses 0..31, data 0xB0000000+i; Stall low after DONE.
- Same-ID switch:
  - Stimulus: Load_Proc returns Proc_ID equal to Old_ID (0).
  - Required: no Reg_Wr_En pulse; Busy drops 1 cycle after Load_Proc is sampled.
- Timeout:
  - Stimulus: hold Load_Proc=0.
  - Required: Timeout_Err=1 after 1023 WAIT_LOAD cycles; no restore writes; Stall released.
- Overrun/retrigger:
  - Stimulus: second Snapshot edge during SAVE; Snapshot held high throughout.
  - Required: Overrun=1; exactly one switch performed.
- Reset mid-RESTORE:
  - Stimulus: assert Reset at restore idx=10.
  - Required: next cycle all outputs 0, FSM IDLE; ctx RAM contents unchanged.

Source files
------------

// File: rtl/context_switch_engine_pkg.sv
// Shared types and default sizing for the context switch engine slice.
package context_switch_engine_pkg;

  localparam int unsigned PROC_ID_W      = 2;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_COUNT  = 32;
  localparam int unsigned DEF_ADDR_W     = 5;
  localparam int unsigned DEF_PROC_COUNT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_SAVE_FLUSH,
    ST_UPDATE,
    ST_WAIT_LOAD,
    ST_RESTORE,
    ST_RESTORE_FLUSH,
    ST_DONE
  } cse_state_e;

endpackage

// File: rtl/context_switch_engine_if.sv
// Scheduler handshake plus register-file port seen by the context switch engine.
interface context_switch_engine_if
  import context_switch_engine_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic                 Snapshot;
  logic                 Load_Proc;
  logic [PROC_ID_W-1:0] Proc_ID;
  logic [DATA_W-1:0]    Reg_Rd_Data;
  logic [ADDR_W-1:0]    Reg_Addr;
  logic [DATA_W-1:0]    Reg_Wr_Data;
  logic                 Reg_Wr_En;
  logic                 Update_PC;

  modport master (
    output Snapshot, Load_Proc, Proc_ID, Reg_Rd_Data,
    input  Reg_Addr, Reg_Wr_Data, Reg_Wr_En, Update_PC
  );

  modport slave (
    input  Snapshot, Load_Proc, Proc_ID, Reg_Rd_Data,
    output Reg_Addr, Reg_Wr_Data, Reg_Wr_En, Update_PC
  );

endinterface

// File: rtl/context_switch_engine_ram.sv
// Per-process context store: single-port synchronous RAM, one-cycle read latency.
module context_switch_engine_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned AW     = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/context_switch_engine.sv
// Saves the outgoing process's register file, hands the PC swap to the scheduler,
// then restores the incoming process's registers while holding the core stalled.
module context_switch_engine
  import context_switch_engine_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned REG_COUNT    = DEF_REG_COUNT,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned PROC_COUNT   = DEF_PROC_COUNT,
  parameter int unsigned UPD_PULSE    = 2,
  parameter int unsigned LOAD_TIMEOUT = 1023
) (
  input  logic                   Fast_Clock,
  input  logic                   Reset,
  context_switch_engine_if.slave bus,
  output logic                   Stall,
  output logic                   Busy,
  output logic                   Overrun,
  output logic                   Timeout_Err
);

  localparam int unsigned RAM_AW    = PROC_ID_W + ADDR_W;
  localparam int unsigned RAM_DEPTH = PROC_COUNT * REG_COUNT;
  localparam int unsigned TMR_W     = $clog2(LOAD_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);
  localparam logic [TMR_W-1:0]  UPD_LAST = TMR_W'(UPD_PULSE - 1);
  localparam logic [TMR_W-1:0]  TMO_LAST = TMR_W'(LOAD_TIMEOUT - 1);

  cse_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [TMR_W-1:0]     cnt_q, cnt_d;
  logic [PROC_ID_W-1:0] old_id_q, old_id_d;
  logic [PROC_ID_W-1:0] new_id_q, new_id_d;
  logic                 snap_q, snap_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;

  logic                 start;
  logic [ADDR_W-1:0]    idx_prev;
  logic [ADDR_W-1:0]    reg_addr;
  logic [DATA_W-1:0]    reg_wr_data;
  logic                 reg_wr_en;
  logic                 update_pc;
  logic                 ram_we;
  logic [RAM_AW-1:0]    ram_addr;
  logic [DATA_W-1:0]    ram_wdata;
  logic [DATA_W-1:0]    ram_rdata;

  always_ff @(posedge Fast_Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      old_id_q  <= '0;
      new_id_q  <= '0;
      snap_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      old_id_q  <= old_id_d;
      new_id_q  <= new_id_d;
      snap_q    <= snap_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    old_id_d    = old_id_q;
    new_id_d    = new_id_q;
    snap_d      = bus.Snapshot;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;
    reg_addr    = '0;
    reg_wr_data = '0;
    reg_wr_en   = 1'b0;
    update_pc   = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    start    = bus.Snapshot & ~snap_q;
    idx_prev = idx_q - ADDR_W'(1);

    if (start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          old_id_d = bus.Proc_ID;
          idx_d    = '0;
          state_d  = ST_SAVE;
        end
      end
      // Read data trails the issued address by one cycle, so each cycle stores idx-1.
      ST_SAVE: begin
        reg_addr  = idx_q;
        ram_addr  = {old_id_q, idx_prev};
        ram_wdata = bus.Reg_Rd_Data;
        ram_we    = (idx_q != '0);
        idx_d     = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_SAVE_FLUSH;
        end
      end
      ST_SAVE_FLUSH: begin
        ram_addr  = {old_id_q, LAST_IDX};
        ram_wdata = bus.Reg_Rd_Data;
        ram_we    = 1'b1;
        cnt_d     = '0;
        state_d   = ST_UPDATE;
      end
      // cnt_q times both the Update_PC pulse and the Load_Proc wait.
      ST_UPDATE: begin
        update_pc = 1'b1;
        cnt_d     = cnt_q + TMR_W'(1);
        if (cnt_q == UPD_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LOAD;
        end
      end
      ST_WAIT_LOAD: begin
        if (bus.Load_Proc) begin
          new_id_d = bus.Proc_ID;
          idx_d    = '0;
          state_d  = (bus.Proc_ID == old_id_q) ? ST_DONE : ST_RESTORE;
        end else if (cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + TMR_W'(1);
        end
      end
      ST_RESTORE: begin
        ram_addr = {new_id_q, idx_q};
        if (idx_q != '0) begin
          reg_addr    = idx_prev;
          reg_wr_data = ram_rdata;
          reg_wr_en   = 1'b1;
        end
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_RESTORE_FLUSH;
        end
      end
      ST_RESTORE_FLUSH: begin
        reg_addr    = LAST_IDX;
        reg_wr_data = ram_rdata;
        reg_wr_en   = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  context_switch_engine_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (RAM_DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (Fast_Clock),
    .we    (ram_we & ~Reset),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.Reg_Addr    = reg_addr;
  assign bus.Reg_Wr_Data = reg_wr_data;
  assign bus.Reg_Wr_En   = reg_wr_en;
  assign bus.Update_PC   = update_pc;
  assign Stall           = (state_q != ST_IDLE);
  assign Busy            = (state_q != ST_IDLE);
  assign Overrun         = overrun_q;
  assign Timeout_Err     = timeout_q;

endmodule

// File: tb/tb_context_switch_engine.sv
// Scoreboard bench for context_switch_engine: register-file model, expected restore
// writes queued when each switch is launched and matched against observed writes.
module tb_context_switch_engine;

  localparam int unsigned DW = 32;
  localparam int unsigned RC = 32;
  localparam int unsigned AW = 5;

  logic Fast_Clock = 1'b0;
  logic Reset;
  logic Stall, Busy, Overrun, Timeout_Err;

  context_switch_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  context_switch_engine #(
    .DATA_W       (DW),
    .REG_COUNT    (RC),
    .ADDR_W       (AW),
    .PROC_COUNT   (4),
    .UPD_PULSE    (2),
    .LOAD_TIMEOUT (1023)
  ) dut (
    .Fast_Clock  (Fast_Clock),
    .Reset       (Reset),
    .bus         (bus),
    .Stall       (Stall),
    .Busy        (Busy),
    .Overrun     (Overrun),
    .Timeout_Err (Timeout_Err)
  );

  always #5 Fast_Clock = ~Fast_Clock;

  logic [DW-1:0] regs [RC];
  logic [DW-1:0] rd_q;
  always @(posedge Fast_Clock) rd_q <= regs[bus.Reg_Addr];
  assign bus.Reg_Rd_Data = rd_q;

  logic [AW+DW-1:0] act_q[$];
  logic [AW+DW-1:0] exp_q[$];
  always @(negedge Fast_Clock)
    if (bus.Reg_Wr_En === 1'b1) act_q.push_back({bus.Reg_Addr, bus.Reg_Wr_Data});

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Fast_Clock);
    #1;
  endtask

  task automatic fill_regs(input logic [DW-1:0] base);
    for (int i = 0; i < RC; i++) regs[i] = base + DW'(i);
  endtask

  task automatic push_restore(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), base + DW'(i)});
  endtask

  // Cycle 1 is the cycle Snapshot is first seen high; returns the cycle Update_PC
  // rises in, how long it stays high, and Stall in cycle 2. Exits in the first
  // cycle after Update_PC falls.
  task automatic run_to_wait(input logic [1:0] id, output int upd_cyc,
                             output int upd_hi, output logic stall_c2);
    int cyc;
    bus.Proc_ID  = id;
    bus.Snapshot = 1'b1;
    cyc = 1;
    step();
    cyc = 2;
    stall_c2 = Stall;
    bus.Snapshot = 1'b0;
    while (bus.Update_PC !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    upd_cyc = (bus.Update_PC === 1'b1) ? cyc : 0;
    upd_hi = 0;
    while (bus.Update_PC === 1'b1 && upd_hi < 10) begin
      upd_hi++;
      step();
    end
  endtask

  // Answers with Load_Proc in the first WAIT_LOAD cycle; counts Busy cycles after.
  task automatic respond_load(input logic [1:0] id, output int busy_cyc);
    bus.Proc_ID   = id;
    bus.Load_Proc = 1'b1;
    step();
    bus.Load_Proc = 1'b0;
    busy_cyc = 0;
    while (Busy === 1'b1 && busy_cyc < 2000) begin
      busy_cyc++;
      step();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.Snapshot = 1'b0; bus.Load_Proc = 1'b0; bus.Proc_ID = '0;
    repeat (3) step();
    n_total++;
    if ({bus.Reg_Addr, bus.Reg_Wr_Data, bus.Reg_Wr_En, bus.Update_PC} !== '0)
      $display("FAIL reset_bus: got addr %0d data %h we %b upd %b want all 0",
               bus.Reg_Addr, bus.Reg_Wr_Data, bus.Reg_Wr_En, bus.Update_PC);
    else n_pass++;
    n_total++;
    if ({Stall, Busy, Overrun, Timeout_Err} !== 4'b0000)
      $display("FAIL reset_status: got %b want 0000", {Stall, Busy, Overrun, Timeout_Err});
    else n_pass++;
    Reset = 1'b0;
    step();
  endtask

  // Same-ID switch on slot 2 fills ctx[2] with 0xB0000000+i for later restores.
  task automatic test_preload();
    int uc, uh, bc; logic s2;
    act_q.delete(); exp_q.delete();
    fill_regs(32'hB000_0000);
    run_to_wait(2'd2, uc, uh, s2);
    respond_load(2'd2, bc);
    n_total++;
    if (act_q.size() !== 0) $display("FAIL preload_no_wr: got %0d writes want 0", act_q.size());
    else n_pass++;
  endtask

  task automatic test_basic_round_trip();
    int uc, uh, bc; logic s2;
    logic [AW+DW-1:0] a, e;
    act_q.delete(); exp_q.delete();
    fill_regs(32'hA000_0000);
    push_restore(32'hB000_0000, RC);
    run_to_wait(2'd1, uc, uh, s2);
    n_total++;
    if (s2 !== 1'b1) $display("FAIL stall_next_cycle: got %b want 1", s2); else n_pass++;
    n_total++;
    if (uc !== 35) $display("FAIL update_latency: got cycle %0d want 35", uc); else n_pass++;
    n_total++;
    if (uh !== 2) $display("FAIL update_width: got %0d want 2", uh); else n_pass++;
    respond_load(2'd2, bc);
    n_total++;
    if (bc !== 34) $display("FAIL restore_busy_len: got %0d want 34", bc); else n_pass++;
    n_total++;
    if ({Stall, Busy} !== 2'b00) $display("FAIL rt_release: got %b want 00", {Stall, Busy});
    else n_pass++;
    n_total++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL rt_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (a !== e) $display("FAIL rt_wr: got addr %0d data %h want addr %0d data %h",
                            a[AW+DW-1:DW], a[DW-1:0], e[AW+DW-1:DW], e[DW-1:0]);
      else n_pass++;
    end
  endtask

  // Restoring slot 1 checks what the basic save wrote there.
  task automatic test_restore_saved();
    int uc, uh, bc; logic s2;
    logic [AW+DW-1:0] a, e;
    act_q.delete(); exp_q.delete();
    fill_regs(32'hC000_0000);
    push_restore(32'hA000_0000, RC);
    run_to_wait(2'd3, uc, uh, s2);
    respond_load(2'd1, bc);
    n_total++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL saved_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (a !== e) $display("FAIL saved_wr: got addr %0d data %h want addr %0d data %h",
                            a[AW+DW-1:DW], a[DW-1:0], e[AW+DW-1:DW], e[DW-1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_same_id();
    int uc, uh, bc; logic s2;
    act_q.delete(); exp_q.delete();
    fill_regs(32'hD000_0000);
    run_to_wait(2'd0, uc, uh, s2);
    respond_load(2'd0, bc);
    n_total++;
    if (bc !== 1) $display("FAIL same_id_busy: got %0d busy cycles want 1", bc); else n_pass++;
    n_total++;
    if (act_q.size() !== 0) $display("FAIL same_id_no_wr: got %0d writes want 0", act_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int uc, uh, n; logic s2;
    act_q.delete(); exp_q.delete();
    fill_regs(32'hE000_0000);
    run_to_wait(2'd3, uc, uh, s2);
    n = 1;
    n_total++;
    if (Timeout_Err !== 1'b0) $display("FAIL timeout_early: got %b want 0", Timeout_Err);
    else n_pass++;
    while (Timeout_Err !== 1'b1 && n < 1100) begin
      step();
      n++;
    end
    n_total++;
    if (n !== 1024) $display("FAIL timeout_cycle: got %0d want 1024", n); else n_pass++;
    step();
    n_total++;
    if ({Stall, Busy, Timeout_Err} !== 3'b001)
      $display("FAIL timeout_release: got %b want 001", {Stall, Busy, Timeout_Err});
    else n_pass++;
    n_total++;
    if (act_q.size() !== 0) $display("FAIL timeout_no_wr: got %0d writes want 0", act_q.size());
    else n_pass++;
  endtask

  task automatic test_overrun();
    int rises, n, bc; logic prev_upd;
    act_q.delete(); exp_q.delete();
    fill_regs(32'hF000_0000);
    bus.Proc_ID = 2'd0;
    bus.Snapshot = 1'b1;
    step();
    bus.Snapshot = 1'b0;
    step();
    bus.Snapshot = 1'b1;
    step();
    n_total++;
    if (Overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", Overrun); else n_pass++;
    rises = 0; prev_upd = 1'b0; n = 0;
    while (!(prev_upd === 1'b1 && bus.Update_PC === 1'b0) && n < 200) begin
      if (bus.Update_PC === 1'b1 && prev_upd === 1'b0) rises++;
      prev_upd = bus.Update_PC;
      step();
      n++;
    end
    respond_load(2'd0, bc);
    n = 0;
    repeat (60) begin
      step();
      if (Busy === 1'b1) n++;
      if (bus.Update_PC === 1'b1) rises++;
    end
    n_total++;
    if (rises !== 1) $display("FAIL overrun_one_switch: got %0d update pulses want 1", rises);
    else n_pass++;
    n_total++;
    if (n !== 0) $display("FAIL no_retrigger: got %0d busy cycles want 0", n); else n_pass++;
    bus.Snapshot = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_restore();
    int uc, uh, n; logic s2;
    logic [AW+DW-1:0] a, e;
    act_q.delete(); exp_q.delete();
    fill_regs(32'h1234_0000);
    push_restore(32'hA000_0000, 10);
    run_to_wait(2'd3, uc, uh, s2);
    bus.Proc_ID = 2'd1;
    bus.Load_Proc = 1'b1;
    step();
    bus.Load_Proc = 1'b0;
    n = 0;
    while (!(bus.Reg_Wr_En === 1'b1 && bus.Reg_Addr === AW'(9)) && n < 100) begin
      step();
      n++;
    end
    Reset = 1'b1;
    step();
    n_total++;
    if ({bus.Reg_Addr, bus.Reg_Wr_Data, bus.Reg_Wr_En, bus.Update_PC} !== '0)
      $display("FAIL midreset_bus: got addr %0d data %h we %b upd %b want all 0",
               bus.Reg_Addr, bus.Reg_Wr_Data, bus.Reg_Wr_En, bus.Update_PC);
    else n_pass++;
    n_total++;
    if ({Stall, Busy, Overrun, Timeout_Err} !== 4'b0000)
      $display("FAIL midreset_status: got %b want 0000", {Stall, Busy, Overrun, Timeout_Err});
    else n_pass++;
    Reset = 1'b0;
    step();
    n_total++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL midreset_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (a !== e) $display("FAIL midreset_wr: got addr %0d data %h want addr %0d data %h",
                            a[AW+DW-1:DW], a[DW-1:0], e[AW+DW-1:DW], e[DW-1:0]);
      else n_pass++;
    end
  endtask

  // Slot 1 must still hold the basic-save data after the aborted restore.
  task automatic test_ram_intact();
    int uc, uh, bc; logic s2;
    logic [AW+DW-1:0] a, e;
    act_q.delete(); exp_q.delete();
    fill_regs(32'h5555_0000);
    push_restore(32'hA000_0000, RC);
    run_to_wait(2'd2, uc, uh, s2);
    n_total++;
    if (uc !== 35) $display("FAIL post_reset_latency: got cycle %0d want 35", uc); else n_pass++;
    respond_load(2'd1, bc);
    n_total++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL intact_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (a !== e) $display("FAIL intact_wr: got addr %0d data %h want addr %0d data %h",
                            a[AW+DW-1:DW], a[DW-1:0], e[AW+DW-1:DW], e[DW-1:0]);
      else n_pass++;
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.Snapshot = 1'b0;
    bus.Load_Proc = 1'b0;
    bus.Proc_ID = '0;
    test_reset();
    test_preload();
    test_basic_round_trip();
    test_restore_saved();
    test_same_id();
    test_timeout();
    test_overrun();
    test_reset_mid_restore();
    test_ram_intact();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
